// File: rtl/uart_fifo_bridge_pkg.sv
// -----------------------------------------------------------------------------
// uart_fifo_bridge_pkg
// Shared definitions for the UART FIFO bridge:
//   - poll FSM state encodings
//   - CPU register addresses (0..3) and simpleuart register addresses
//   - status register bit positions
//   - holdoff reload helpers, derived from the simpleuart divider
// -----------------------------------------------------------------------------
package uart_fifo_bridge_pkg;

  // Poll FSM states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    DAT_RD  = 3'd3,
    DAT_CAP = 3'd4,
    WR      = 3'd5
  } poll_state_e;

  // CPU-side register map.
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_CLEAR  = 2'd3;

  // simpleuart register map.
  localparam logic UART_REG_DATA   = 1'b0;
  localparam logic UART_REG_STATUS = 1'b1;

  // Status register bit positions.
  localparam int STAT_RX_NONEMPTY = 0;
  localparam int STAT_RX_FULL     = 1;
  localparam int STAT_TX_EMPTY    = 2;
  localparam int STAT_TX_FULL     = 3;
  localparam int STAT_TX_OVF      = 4;
  localparam int STAT_RX_OVF      = 5;

  // Value returned by a data read while RX is empty.
  localparam logic [7:0] RX_EMPTY_BYTE = 8'hFF;

  // After reset the UART emits a dummy frame; hold TX off for 1.5 frames.
  function automatic int holdoff_after_reset(input int uart_div);
    return 15 * (uart_div + 2) + 2;
  endfunction

  // One 10-bit frame per transmitted byte.
  function automatic int holdoff_after_frame(input int uart_div);
    return 10 * (uart_div + 2) + 2;
  endfunction

endpackage

// File: rtl/uart_fifo_bridge_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word-fall-through head output.
// Push while full and pop while empty are ignored; a simultaneous legal push
// and pop both take effect and leave the count unchanged.
// Ports:
//   CLK, RESET        clock, asynchronous active-high reset
//   push, push_data   write request and data
//   pop               read request (head advances)
//   head              current head entry (undefined when empty)
//   full, empty       occupancy flags
//   count             number of stored entries (DEPTH_LOG2+1 bits)
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = DEPTH[DEPTH_LOG2:0];

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: the storage array has no reset; pointers and count alone define
  // which entries are valid, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or process order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// -----------------------------------------------------------------------------
// uart_fifo_bridge
// Puts an RX and a TX byte FIFO between a CPU register port and a simpleuart.
// A poll FSM repeatedly reads the UART status; when a byte is ready and RX has
// room it reads the byte into RX, otherwise it sends the TX head once the
// frame holdoff counter has expired.
//
// Optional feature (macro UART_FIFO_IRQ_EN): adds a registered IRQ output equal
// to rx_nonempty | rx_ovf | tx_ovf. Without the macro the port does not exist.
//
// Ports:
//   CLK, RESET   clock, asynchronous active-high reset
//   ADDR, DI     CPU register select and write data
//   DO           CPU read data, registered
//   CS, RW       CPU chip select and direction (1 = read)
//   U_ADDR, U_DI, U_CS, U_RW   simpleuart register access
//   U_DO         simpleuart read data
//   IRQ          interrupt (only with UART_FIFO_IRQ_EN)
//
// CPU registers: 0 RX pop / TX push, 1 status, 2 RX count, 3 clear overflows.
// -----------------------------------------------------------------------------
module uart_fifo_bridge
  import uart_fifo_bridge_pkg::*;
#(
  parameter int UART_DIV   = 27,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] ADDR,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       CS,
  input  logic       RW,
  output logic       U_ADDR,
  output logic [7:0] U_DI,
  input  logic [7:0] U_DO,
  output logic       U_CS,
`ifdef UART_FIFO_IRQ_EN
  output logic       IRQ,
`endif
  output logic       U_RW
);

  localparam int HOLD_RESET = holdoff_after_reset(UART_DIV);
  localparam int HOLD_FRAME = holdoff_after_frame(UART_DIV);
  localparam int HOLD_W     = $clog2(HOLD_RESET + 1);

  poll_state_e state;
  poll_state_e next_state;

  logic [HOLD_W-1:0] holdoff;
  logic              holdoff_load;

  logic rx_ovf;
  logic tx_ovf;
  logic rx_ovf_set;

  // CPU decode
  logic cpu_rd;
  logic cpu_wr;
  logic rx_pop;
  logic tx_push;
  logic clear_ovf;

  // FIFO signals
  logic                rx_push;
  logic [7:0]          rx_head;
  logic                rx_full;
  logic                rx_empty;
  logic [DEPTH_LOG2:0] rx_count;
  logic                tx_pop;
  logic [7:0]          tx_head;
  logic                tx_full;
  logic                tx_empty;
  // TX occupancy is not exposed on the CPU register map.
  logic [DEPTH_LOG2:0] tx_count_unused;

  logic [7:0] status;

  assign cpu_rd    = CS && RW;
  assign cpu_wr    = CS && !RW;
  assign rx_pop    = cpu_rd && (ADDR == REG_DATA);
  assign tx_push   = cpu_wr && (ADDR == REG_DATA);
  assign clear_ovf = cpu_wr && (ADDR == REG_CLEAR);

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_rx_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (rx_push),
    .push_data (U_DO),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_tx_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (tx_push),
    .push_data (DI),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count_unused)
  );

  // ---------------------------------------------------------------------------
  // Poll FSM. The UART-side outputs decode straight from the state register,
  // so an asynchronous reset puts them at their idle values immediately.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state   = state;
    U_CS         = 1'b0;
    U_ADDR       = UART_REG_DATA;
    U_RW         = 1'b1;
    U_DI         = 8'h00;
    rx_push      = 1'b0;
    tx_pop       = 1'b0;
    holdoff_load = 1'b0;
    rx_ovf_set   = 1'b0;
    case (state)
      IDLE: begin
        next_state = ST_RD;
      end
      ST_RD: begin
        U_CS       = 1'b1;
        U_ADDR     = UART_REG_STATUS;
        next_state = ST_CAP;
      end
      ST_CAP: begin
        // U_DO[0] is the UART's ready bit, returned for the ST_RD access.
        if (U_DO[0] && !rx_full) begin
          next_state = DAT_RD;
        end else begin
          // A ready byte with no room stays in the UART and is flagged.
          rx_ovf_set = U_DO[0];
          if (!tx_empty && (holdoff == '0)) begin
            next_state = WR;
          end else begin
            next_state = IDLE;
          end
        end
      end
      DAT_RD: begin
        U_CS       = 1'b1;
        next_state = DAT_CAP;
      end
      DAT_CAP: begin
        rx_push    = 1'b1;
        next_state = IDLE;
      end
      WR: begin
        U_CS         = 1'b1;
        U_RW         = 1'b0;
        U_DI         = tx_head;
        tx_pop       = 1'b1;
        holdoff_load = 1'b1;
        next_state   = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Holdoff keeps the next write from overrunning the UART's current frame.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      holdoff <= HOLD_W'(HOLD_RESET);
    end else if (holdoff_load) begin
      holdoff <= HOLD_W'(HOLD_FRAME);
    end else if (holdoff != '0) begin
      holdoff <= holdoff - 1'b1;
    end
  end

  // Sticky overflow flags; a new overflow in the same cycle as a clear wins.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_ovf <= 1'b0;
      tx_ovf <= 1'b0;
    end else begin
      if (clear_ovf) begin
        rx_ovf <= 1'b0;
        tx_ovf <= 1'b0;
      end
      if (rx_ovf_set) begin
        rx_ovf <= 1'b1;
      end
      if (tx_push && tx_full) begin
        tx_ovf <= 1'b1;
      end
    end
  end

  always_comb begin
    status                   = 8'h00;
    status[STAT_RX_NONEMPTY] = !rx_empty;
    status[STAT_RX_FULL]     = rx_full;
    status[STAT_TX_EMPTY]    = tx_empty;
    status[STAT_TX_FULL]     = tx_full;
    status[STAT_TX_OVF]      = tx_ovf;
    status[STAT_RX_OVF]      = rx_ovf;
  end

  // CPU read data, captured on the edge that ends the CS cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      DO <= 8'h00;
    end else if (cpu_rd) begin
      case (ADDR)
        REG_DATA:   DO <= rx_empty ? RX_EMPTY_BYTE : rx_head;
        REG_STATUS: DO <= status;
        REG_COUNT:  DO <= 8'(rx_count);
        default:    DO <= 8'h00;
      endcase
    end
  end

`ifdef UART_FIFO_IRQ_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      IRQ <= 1'b0;
    end else begin
      IRQ <= !rx_empty || rx_ovf || tx_ovf;
    end
  end
`endif

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// -----------------------------------------------------------------------------
// tb_uart_fifo_bridge
// Bench for uart_fifo_bridge with a behavioural simpleuart and a queue-based
// model of the CPU-visible FIFO contents and flags.
// -----------------------------------------------------------------------------
module tb_uart_fifo_bridge;

  localparam int UART_DIV   = 27;
  localparam int DEPTH      = 8;
  localparam int HOLD_RESET = 15 * (UART_DIV + 2) + 2;
  localparam int HOLD_FRAME = 10 * (UART_DIV + 2) + 2;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [1:0] ADDR = 2'd0;
  logic [7:0] DI = 8'h00;
  logic [7:0] DO;
  logic       CS = 1'b0;
  logic       RW = 1'b1;
  logic       U_ADDR;
  logic [7:0] U_DI;
  logic [7:0] U_DO = 8'h00;
  logic       U_CS;
  logic       U_RW;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  uart_fifo_bridge #(
    .UART_DIV   (UART_DIV),
    .DEPTH_LOG2 (3)
  ) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .ADDR   (ADDR),
    .DI     (DI),
    .DO     (DO),
    .CS     (CS),
    .RW     (RW),
    .U_ADDR (U_ADDR),
    .U_DI   (U_DI),
    .U_DO   (U_DO),
    .U_CS   (U_CS),
    .U_RW   (U_RW)
  );

  // ---------------------------------------------------------------------------
  // simpleuart model: registered read data; a data read consumes the byte.
  // ---------------------------------------------------------------------------
  logic [7:0] uart_rx_q[$];
  logic [7:0] tx_log_data[$];
  int         tx_log_cyc[$];
  int         cyc = 0;
  int         rel_cyc = 0;

  always @(posedge CLK) begin
    cyc = cyc + 1;
    if (U_CS === 1'b1) begin
      if (U_RW) begin
        if (U_ADDR) begin
          U_DO <= {7'b0, (uart_rx_q.size() > 0)};
        end else if (uart_rx_q.size() > 0) begin
          U_DO <= uart_rx_q.pop_front();
        end else begin
          U_DO <= 8'h00;
        end
      end else begin
        tx_log_data.push_back(U_DI);
        tx_log_cyc.push_back(cyc);
      end
    end
  end

  // Reference model of CPU-visible state.
  logic [7:0] rx_model[$];
  int         tx_n;
  bit         rx_ovf_m;
  bit         tx_ovf_m;

  function automatic logic [7:0] exp_status(input int rx_n, input int tx_cnt,
                                            input bit rxo, input bit txo);
    logic [7:0] s;
    s    = 8'h00;
    s[0] = (rx_n > 0);
    s[1] = (rx_n == DEPTH);
    s[2] = (tx_cnt == 0);
    s[3] = (tx_cnt == DEPTH);
    s[4] = txo;
    s[5] = rxo;
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Bus helpers
  // ---------------------------------------------------------------------------
  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge CLK);
    CS = 1'b1; RW = 1'b0; ADDR = a; DI = d;
    @(posedge CLK);
    #1;
    CS = 1'b0; RW = 1'b1;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge CLK);
    CS = 1'b1; RW = 1'b1; ADDR = a;
    @(posedge CLK);
    #1;
    d  = DO;
    CS = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RESET = 1'b1;
    wait_cycles(3);
    uart_rx_q.delete();
    tx_log_data.delete();
    tx_log_cyc.delete();
    rx_model.delete();
    tx_n = 0; rx_ovf_m = 0; tx_ovf_m = 0;
    RESET   = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wait_uart_rx_size(input int target, input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK);
      if (uart_rx_q.size() == target) begin
        ok = 1;
        return;
      end
    end
  endtask

  task automatic wait_tx_log(input int target, input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK);
      if (tx_log_data.size() >= target) begin
        ok = 1;
        return;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [7:0] d;
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    checks++;
    if ({U_CS, U_RW, U_ADDR, U_DI, DO} !== {1'b0, 1'b1, 1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL reset_outputs: got cs=%b rw=%b addr=%b di=%h do=%h, expected 0 1 0 00 00",
               U_CS, U_RW, U_ADDR, U_DI, DO);
    end
    apply_reset();
    cpu_read(2'd1, d);
    checks++;
    if (d !== 8'h04) begin
      errors++; $display("FAIL reset_status: got %h, expected 04", d);
    end
    cpu_read(2'd0, d);
    checks++;
    if (d !== 8'hFF) begin
      errors++; $display("FAIL reset_empty_pop: got %h, expected ff", d);
    end
    cpu_read(2'd2, d);
    checks++;
    if (d !== 8'h00) begin
      errors++; $display("FAIL reset_count: got %h, expected 00", d);
    end
  endtask

  task automatic test_rx_single();
    logic [7:0] d;
    bit ok;
    uart_rx_q.push_back(8'hA5);
    rx_model.push_back(8'hA5);
    wait_uart_rx_size(0, 20, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rx_single_timeout: got pending=%0d, expected 0", uart_rx_q.size());
    end
    wait_cycles(2);
    cpu_read(2'd2, d);
    checks++;
    if (d !== 8'(rx_model.size())) begin
      errors++; $display("FAIL rx_single_count: got %h, expected %h", d, 8'(rx_model.size()));
    end
    cpu_read(2'd0, d);
    checks++;
    if (d !== rx_model[0]) begin
      errors++; $display("FAIL rx_single_data: got %h, expected %h", d, rx_model[0]);
    end
    void'(rx_model.pop_front());
    cpu_read(2'd2, d);
    checks++;
    if (d !== 8'(rx_model.size())) begin
      errors++; $display("FAIL rx_single_count_after: got %h, expected %h", d, 8'(rx_model.size()));
    end
  endtask

  task automatic test_rx_random();
    logic [7:0] d;
    logic [7:0] b;
    bit ok;
    int n;
    n = $urandom_range(3, 7);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      uart_rx_q.push_back(b);
      rx_model.push_back(b);
    end
    wait_uart_rx_size(0, 15 * n + 20, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rx_random_timeout: got pending=%0d, expected 0", uart_rx_q.size());
    end
    wait_cycles(2);
    cpu_read(2'd2, d);
    checks++;
    if (d !== 8'(rx_model.size())) begin
      errors++; $display("FAIL rx_random_count: got %h, expected %h", d, 8'(rx_model.size()));
    end
    while (rx_model.size() > 0) begin
      cpu_read(2'd0, d);
      checks++;
      if (d !== rx_model[0]) begin
        errors++; $display("FAIL rx_random_data: got %h, expected %h", d, rx_model[0]);
      end
      void'(rx_model.pop_front());
    end
    cpu_read(2'd0, d);
    checks++;
    if (d !== 8'hFF) begin
      errors++; $display("FAIL rx_random_underflow: got %h, expected ff", d);
    end
  endtask

  task automatic test_rx_overflow();
    logic [7:0] d;
    logic [7:0] b;
    bit ok;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom_range(0, 255));
      uart_rx_q.push_back(b);
      rx_model.push_back(b);
    end
    wait_uart_rx_size(1, 200, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rx_ovf_fill_timeout: got pending=%0d, expected 1", uart_rx_q.size());
    end
    wait_cycles(30);
    // The ninth byte must still sit in the UART: no data read while full.
    checks++;
    if (uart_rx_q.size() != 1) begin
      errors++; $display("FAIL rx_ovf_no_read: got pending=%0d, expected 1", uart_rx_q.size());
    end
    rx_ovf_m = 1;
    cpu_read(2'd1, d);
    checks++;
    if (d !== exp_status(DEPTH, tx_n, rx_ovf_m, tx_ovf_m)) begin
      errors++; $display("FAIL rx_ovf_status: got %h, expected %h", d,
                         exp_status(DEPTH, tx_n, rx_ovf_m, tx_ovf_m));
    end
    cpu_read(2'd0, d);
    checks++;
    if (d !== rx_model[0]) begin
      errors++; $display("FAIL rx_ovf_first_pop: got %h, expected %h", d, rx_model[0]);
    end
    void'(rx_model.pop_front());
    wait_uart_rx_size(0, 40, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rx_ovf_refill_timeout: got pending=%0d, expected 0", uart_rx_q.size());
    end
    wait_cycles(2);
    cpu_read(2'd2, d);
    checks++;
    if (d !== 8'(rx_model.size())) begin
      errors++; $display("FAIL rx_ovf_refill_count: got %h, expected %h", d, 8'(rx_model.size()));
    end
    while (rx_model.size() > 0) begin
      cpu_read(2'd0, d);
      checks++;
      if (d !== rx_model[0]) begin
        errors++; $display("FAIL rx_ovf_data: got %h, expected %h", d, rx_model[0]);
      end
      void'(rx_model.pop_front());
    end
    cpu_read(2'd1, d);
    checks++;
    if (d !== exp_status(0, tx_n, rx_ovf_m, tx_ovf_m)) begin
      errors++; $display("FAIL rx_ovf_sticky: got %h, expected %h", d,
                         exp_status(0, tx_n, rx_ovf_m, tx_ovf_m));
    end
    cpu_write(2'd3, 8'h00);
    rx_ovf_m = 0;
    cpu_read(2'd1, d);
    checks++;
    if (d !== exp_status(0, tx_n, rx_ovf_m, tx_ovf_m)) begin
      errors++; $display("FAIL rx_ovf_clear: got %h, expected %h", d,
                         exp_status(0, tx_n, rx_ovf_m, tx_ovf_m));
    end
  endtask

  task automatic test_tx_timing();
    bit ok;
    apply_reset();
    cpu_write(2'd0, 8'h31);
    cpu_write(2'd0, 8'h32);
    wait_tx_log(2, 2000, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL tx_timing_timeout: got writes=%0d, expected 2", tx_log_data.size());
    end else begin
      checks++;
      if (tx_log_data[0] !== 8'h31) begin
        errors++; $display("FAIL tx_first_data: got %h, expected 31", tx_log_data[0]);
      end
      checks++;
      if (tx_log_cyc[0] - rel_cyc < HOLD_RESET) begin
        errors++; $display("FAIL tx_first_holdoff: got %0d cycles, expected >= %0d",
                           tx_log_cyc[0] - rel_cyc, HOLD_RESET);
      end
      checks++;
      if (tx_log_data[1] !== 8'h32) begin
        errors++; $display("FAIL tx_second_data: got %h, expected 32", tx_log_data[1]);
      end
      checks++;
      if (tx_log_cyc[1] - tx_log_cyc[0] < HOLD_FRAME) begin
        errors++; $display("FAIL tx_second_gap: got %0d cycles, expected >= %0d",
                           tx_log_cyc[1] - tx_log_cyc[0], HOLD_FRAME);
      end
    end
  endtask

  task automatic test_tx_overflow();
    logic [7:0] d;
    logic [7:0] b;
    logic [7:0] sent[$];
    bit ok;
    apply_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom_range(0, 255));
      cpu_write(2'd0, b);
      if (tx_n < DEPTH) begin
        sent.push_back(b);
        tx_n++;
      end else begin
        tx_ovf_m = 1;
      end
    end
    cpu_read(2'd1, d);
    checks++;
    if (d !== exp_status(0, tx_n, rx_ovf_m, tx_ovf_m)) begin
      errors++; $display("FAIL tx_ovf_status: got %h, expected %h", d,
                         exp_status(0, tx_n, rx_ovf_m, tx_ovf_m));
    end
    // Writes to the status and count addresses have no effect.
    cpu_write(2'd1, 8'hFF);
    cpu_write(2'd2, 8'hFF);
    cpu_write(2'd3, 8'h00);
    tx_ovf_m = 0;
    cpu_read(2'd1, d);
    checks++;
    if (d !== exp_status(0, tx_n, rx_ovf_m, tx_ovf_m)) begin
      errors++; $display("FAIL tx_ovf_clear: got %h, expected %h", d,
                         exp_status(0, tx_n, rx_ovf_m, tx_ovf_m));
    end
    wait_tx_log(DEPTH, HOLD_RESET + DEPTH * (HOLD_FRAME + 10), ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL tx_drain_timeout: got writes=%0d, expected %0d",
                         tx_log_data.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        checks++;
        if (tx_log_data[i] !== sent[i]) begin
          errors++; $display("FAIL tx_drain_data[%0d]: got %h, expected %h", i, tx_log_data[i], sent[i]);
        end
        if (i > 0) begin
          checks++;
          if (tx_log_cyc[i] - tx_log_cyc[i-1] < HOLD_FRAME) begin
            errors++; $display("FAIL tx_drain_gap[%0d]: got %0d, expected >= %0d", i,
                               tx_log_cyc[i] - tx_log_cyc[i-1], HOLD_FRAME);
          end
        end
      end
    end
    wait_cycles(HOLD_FRAME + 50);
    tx_n = 0;
    checks++;
    if (tx_log_data.size() != DEPTH) begin
      errors++; $display("FAIL tx_dropped_byte_sent: got writes=%0d, expected %0d",
                         tx_log_data.size(), DEPTH);
    end
    cpu_read(2'd1, d);
    checks++;
    if (d !== exp_status(0, tx_n, rx_ovf_m, tx_ovf_m)) begin
      errors++; $display("FAIL tx_drained_status: got %h, expected %h", d,
                         exp_status(0, tx_n, rx_ovf_m, tx_ovf_m));
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic [7:0] b;
    bit found;
    cpu_read(2'd1, d);
    b = 8'($urandom_range(0, 255));
    uart_rx_q.push_back(b);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (U_CS === 1'b1 && U_RW === 1'b1 && U_ADDR === 1'b0) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL reset_mid_no_dat_rd: got none in 50 cycles, expected a data read");
    end
    #1;
    RESET = 1'b1;
    #1;
    checks++;
    if ({U_CS, U_RW, U_ADDR, U_DI, DO} !== {1'b0, 1'b1, 1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL reset_mid_outputs: got cs=%b rw=%b addr=%b di=%h do=%h, expected 0 1 0 00 00",
               U_CS, U_RW, U_ADDR, U_DI, DO);
    end
    wait_cycles(2);
    checks++;
    if (uart_rx_q.size() != 1) begin
      errors++; $display("FAIL reset_mid_uart_byte: got pending=%0d, expected 1", uart_rx_q.size());
    end
    RESET = 1'b0;
    cpu_read(2'd2, d);
    checks++;
    if (d !== 8'h00) begin
      errors++; $display("FAIL reset_mid_no_push: got %h, expected 00", d);
    end
    wait_cycles(12);
    cpu_read(2'd0, d);
    checks++;
    if (d !== b) begin
      errors++; $display("FAIL reset_mid_reread: got %h, expected %h", d, b);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_rx_single();
    test_rx_random();
    test_rx_overflow();
    test_tx_timing();
    test_tx_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
